// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Purpose  : Converts the standard-mode FIFO read port into a valid/ready
//            stream. A read is issued only when a buffer slot is guaranteed
//            for the returning word. With a 2-entry skid buffer this gives
//            one word per cycle at full throughput.
// Ports    : clk, reset (sync, active-high), flush (sync discard)
//            fifo_empty, fifo_read_req, fifo_read_data  - FIFO read side
//            out_valid, out_ready, out_data             - stream side
//            level                                      - buffered words 0..2
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             fifo_empty,
  output logic             fifo_read_req,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] r_buf [2];
  logic             r_head;
  logic [1:0]       r_count;
  logic             r_inflight;

  logic             w_pop;
  logic [1:0]       w_credit;
  logic             w_wr_idx;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head ? r_buf[1] : r_buf[0];
  assign level     = r_count;
  assign w_pop     = out_valid & out_ready;

  // Slots committed after this cycle: buffered plus in-flight, minus the
  // word leaving now. The credit rule keeps count+inflight <= 2 and a pop
  // only happens with count >= 1, so this never wraps. It is also the next
  // count, because the in-flight word lands in the buffer this cycle.
  assign w_credit  = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

  assign fifo_read_req = ~reset & ~flush & ~fifo_empty & (w_credit < 2'd2);

  // Tail slot is (head + count) mod 2. When a pop and a push coincide with
  // one word buffered, the head moves onto exactly the slot being written.
  assign w_wr_idx  = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_inflight <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else if (flush) begin
      // The word returning this cycle is discarded along with the buffer.
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_count    <= w_credit;
      r_head     <= r_head ^ w_pop;
      r_inflight <= fifo_read_req;
      if (r_inflight) begin
        r_buf[w_wr_idx] <= fifo_read_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Purpose  : Directed and random stimulus for fifo_rd_stream. Checks against
//            a queue model of the stream: words buffered, words in flight,
//            and the FIFO contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       fifo_empty;
  logic       fifo_read_req;
  logic [7:0] fifo_read_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] level;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .fifo_empty     (fifo_empty),
    .fifo_read_req  (fifo_read_req),
    .fifo_read_data (fifo_read_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .level          (level)
  );

  logic [7:0] src[$];   // words still in the FIFO
  logic [7:0] bq[$];    // words the stream should be holding
  logic [7:0] fq[$];    // word read last cycle, arriving now

  int  checks = 0;
  int  errors = 0;
  bit  known = 0;       // model valid once a reset edge has been seen
  bit  prev_rst = 0;
  bit  prev_req = 0;
  int  req_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs with the model,
  // advance the model, then clock the design and return the FIFO data.
  task automatic cycle(input bit r, input bit fl, input bit hold, input bit rdy);
    logic [7:0] nxt;
    bit ev;
    bit pop;
    bit er;
    int sum;
    reset      = r;
    flush      = fl;
    out_ready  = rdy;
    fifo_empty = hold || (src.size() == 0);
    #1;
    ev = known && (bq.size() != 0);
    if (known) begin
      chk("out_valid", out_valid, ev);
      chk("level", level, bq.size());
      chk("level_max", (level <= 2), 1);
      chk("count_plus_inflight", ({30'd0, level} + prev_req) <= 2, 1);
      if (ev) chk("out_data", out_data, bq[0]);
      else if (prev_rst) chk("out_data_reset", out_data, 0);
    end
    pop = ev && rdy;
    sum = bq.size() + fq.size() - (pop ? 1 : 0);
    er  = !r && !fl && !fifo_empty && (sum < 2);
    chk("read_req", fifo_read_req, er);

    if (r || fl) begin
      bq.delete();
      fq.delete();
    end else begin
      if (pop) void'(bq.pop_front());
      if (fq.size() != 0) bq.push_back(fq.pop_front());
    end
    if (er) begin
      nxt = src.pop_front();
      fq.push_back(nxt);
    end else begin
      nxt = 8'($urandom);
    end
    prev_req = fifo_read_req;
    if (fifo_read_req) req_cnt++;

    @(posedge clk);
    #1;
    fifo_read_data = nxt;
    if (r) known = 1;
    prev_rst = r;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    fifo_empty = 1'b0; fifo_read_data = 8'h00;

    // Reset with a non-empty FIFO, then three words streamed back-to-back.
    src = '{8'h11, 8'h22, 8'h33};
    repeat (3) cycle(1, 0, 0, 0);
    req_cnt = 0;
    repeat (8) cycle(0, 0, 0, 1);
    chk("three_word_reads", req_cnt, 3);

    // Back-pressure: only two words may be fetched, then drain all eight.
    for (int i = 0; i < 8; i++) src.push_back(8'hA0 + 8'(i));
    req_cnt = 0;
    repeat (6) cycle(0, 0, 0, 0);
    chk("backpressure_reads", req_cnt, 2);
    chk("backpressure_level", level, 2);
    chk("backpressure_head", out_data, 8'hA0);
    repeat (12) cycle(0, 0, 0, 1);

    // Toggling ready with a continuously non-empty FIFO.
    for (int i = 0; i < 24; i++) src.push_back(8'h40 + 8'(i));
    for (int i = 0; i < 30; i++) cycle(0, 0, 0, (i % 2) == 0);
    src.delete();
    repeat (6) cycle(0, 0, 0, 1);

    // Flush with one word buffered and one in flight.
    src = '{8'h01, 8'h02, 8'h03, 8'h04};
    repeat (2) cycle(0, 0, 0, 0);
    chk("preflush_level", level, 1);
    cycle(0, 1, 0, 0);
    chk("postflush_valid", out_valid, 0);
    chk("postflush_level", level, 0);
    repeat (6) cycle(0, 0, 0, 1);

    // A single word: empty rises right after the read is accepted.
    src = '{8'h5A};
    req_cnt = 0;
    repeat (5) cycle(0, 0, 0, 1);
    chk("single_word_reads", req_cnt, 1);

    // Random traffic with stalls, flushes and occasional reset.
    for (int i = 0; i < 600; i++) begin
      if (src.size() < 4) begin
        for (int k = 0; k < 8; k++) src.push_back(8'($urandom));
      end
      cycle(($urandom % 150) == 0, ($urandom % 40) == 0,
            ($urandom % 5) == 0, ($urandom % 4) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
